// File: rtl/mini_mips_multicycle.sv
// mini_mips_multicycle
//   Multi-cycle MiniMIPS core for the 16-bit MiniMIPS instruction set. It holds the PC,
//   an 8-entry register file (r0 hard-wired to zero), the ALU and the control FSM.
//   Instructions come from an external synchronous ROM. Data memory is reached over a
//   req/ack handshake whose latency is variable.
// Ports
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   imem_addr / imem_rdata  : instruction address (== pc); instruction word one cycle later
//   dmem_req/we/addr/wdata  : data access, held stable from MEM entry until dmem_ack
//   dmem_rdata / dmem_ack   : load data and a one-cycle completion pulse
//   pc                      : current PC (word address)
//   retire                  : one-cycle pulse in the state that completes an instruction
//   halted / err            : sticky flags for HALT executed / illegal opcode decoded
module mini_mips_multicycle #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted,
    output logic              err
);

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ANDI = 4'h2;
    localparam logic [3:0] OP_ORI  = 4'h3;
    localparam logic [3:0] OP_SLTI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
    } state_t;

    state_t              state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next;
    logic [15:0]         ir_reg;
    logic [DATA_W-1:0]   a_reg, b_reg, alu_reg, mdr_reg;
    logic [DATA_W-1:0]   rf_reg [0:7];

    // Instruction fields, taken from the latched IR
    logic [3:0]          op;
    logic [2:0]          rt, rd, func;
    logic [DATA_W-1:0]   imm_sext;
    logic [PC_W-1:0]     imm_pc, pc_plus1;

    assign op       = ir_reg[15:12];
    assign rt       = ir_reg[8:6];
    assign rd       = ir_reg[5:3];
    assign func     = ir_reg[2:0];
    assign imm_sext = {{(DATA_W-6){ir_reg[5]}}, ir_reg[5:0]};
    assign imm_pc   = {{(PC_W-6){ir_reg[5]}}, ir_reg[5:0]};
    assign pc_plus1 = pc_reg + PC_W'(1);

    // ALU: R-type uses func; I-type ops map onto the matching R function,
    // and lw/sw use add for the address.
    logic [2:0]          alu_fn;
    logic [DATA_W-1:0]   alu_b, alu_res;

    always_comb begin
        alu_fn = 3'd0;
        alu_b  = imm_sext;
        case (op)
            OP_R: begin
                alu_fn = func;
                alu_b  = b_reg;
            end
            OP_ANDI: alu_fn = 3'd2;
            OP_ORI:  alu_fn = 3'd3;
            OP_SLTI: alu_fn = 3'd4;
            default: alu_fn = 3'd0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_fn)
            3'd0: alu_res = a_reg + alu_b;
            3'd1: alu_res = a_reg - alu_b;
            3'd2: alu_res = a_reg & alu_b;
            3'd3: alu_res = a_reg | alu_b;
            3'd4: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_reg) < $signed(alu_b))};
            3'd5: alu_res = a_reg ^ alu_b;
            3'd6: alu_res = a_reg << alu_b[4:0];
            3'd7: alu_res = a_reg >> alu_b[4:0];
            default: alu_res = '0;
        endcase
    end

    logic br_taken;
    assign br_taken = (op == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);

    // Control FSM. HALT and ERROR keep pc unchanged, so pc stays on the
    // halting / faulting instruction.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_WB;
                    OP_LW, OP_SW: state_next = S_MEM;
                    OP_BEQ, OP_BNE: begin
                        retire     = 1'b1;
                        pc_next    = br_taken ? (pc_plus1 + imm_pc) : pc_plus1;
                        state_next = S_FETCH;
                    end
                    OP_HALT: begin
                        retire     = 1'b1;
                        state_next = S_HALT;
                    end
                    default: state_next = S_ERROR;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_SW) begin
                        retire     = 1'b1;
                        pc_next    = pc_plus1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                retire     = 1'b1;
                pc_next    = pc_plus1;
                state_next = S_FETCH;
            end
            S_HALT, S_ERROR: state_next = state_reg;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
            pc_reg    <= PC_W'(RESET_PC);
            ir_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_reg   <= '0;
            mdr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (state_reg == S_DECODE) begin
                // Operands are read straight from the incoming instruction word
                ir_reg <= imem_rdata;
                a_reg  <= rf_reg[imem_rdata[11:9]];
                b_reg  <= rf_reg[imem_rdata[8:6]];
            end
            if (state_reg == S_EXEC) begin
                alu_reg <= alu_res;
            end
            if (state_reg == S_MEM && dmem_ack) begin
                mdr_reg <= dmem_rdata;
            end
        end
    end

    // Register file. Entry 0 is never enabled for writing, so it holds its reset value of 0.
    logic [2:0]        wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;

    assign wb_idx  = (op == OP_R) ? rd : rt;
    assign wb_data = (op == OP_LW) ? mdr_reg : alu_reg;
    assign wb_en   = (state_reg == S_WB) && (wb_idx != 3'd0);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rf
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rf_reg[gi] <= '0;
                end else if (wb_en && (wb_idx == 3'(gi))) begin
                    rf_reg[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // Memory outputs come straight from state and latched operands. They are
    // therefore stable through a MEM wait, and reset drops them at once.
    assign dmem_req   = (state_reg == S_MEM);
    assign dmem_we    = (state_reg == S_MEM) && (op == OP_SW);
    assign dmem_addr  = alu_reg;
    assign dmem_wdata = b_reg;

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign halted    = (state_reg == S_HALT);
    assign err       = (state_reg == S_ERROR);

endmodule

// File: tb/tb_mini_mips_multicycle.sv
module tb_mini_mips_multicycle;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic [15:0] pc;
    logic        retire, halted, err;

    mini_mips_multicycle #(.DATA_W(32), .PC_W(16), .RESET_PC(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc(pc), .retire(retire), .halted(halted), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct { logic [15:0] pc; int lat; } ret_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_t;

    ret_t        ret_q[$];
    mem_t        mem_q[$];
    int          delay_q[$];
    logic [15:0] imem [0:255];
    int          fixed_delay [0:255];
    logic [31:0] resp_mem [logic [31:0]];
    logic [31:0] iss_mem [logic [31:0]];

    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    logic exp_halted, exp_err;
    logic [15:0] exp_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Unwritten data memory has a fixed address-dependent content
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [2:0] fn);
        return {4'h0, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [5:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Random instruction generator; branches only jump forward so programs end
    function automatic logic [15:0] rand_instr();
        int k;
        logic [2:0] rs;
        k  = $urandom_range(0, 9);
        rs = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 7));
        case (k)
            0, 1, 2, 3: return enc_r(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            4: return enc_i(4'($urandom_range(1, 4)), 3'($urandom_range(0, 7)),
                            3'($urandom_range(0, 7)), 6'($urandom));
            5: return enc_i(4'h5, rs, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
            6: return enc_i(4'h6, rs, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
            7: return enc_i(4'($urandom_range(7, 8)), 3'($urandom_range(0, 7)),
                            3'($urandom_range(0, 7)), 6'($urandom_range(0, 3)));
            default: return enc_i(4'h1, 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)),
                                  6'($urandom));
        endcase
    endfunction

    // Instruction-level reference model: runs the program in imem and records,
    // per retired instruction, its pc and cycle count, plus every data access.
    task automatic iss_run(input int max_steps);
        logic [31:0] r [0:7];
        logic [15:0] ipc, nxt, ins;
        logic [3:0]  op;
        logic [2:0]  rs, rt, rd, fn;
        logic [31:0] a, b, imm, res, addr;
        int          lat, d;
        ret_t        rrec;
        mem_t        mrec;
        for (int i = 0; i < 8; i++) r[i] = 32'h0;
        ipc = 16'h0;
        iss_mem.delete();
        exp_halted = 1'b0;
        exp_err    = 1'b0;
        for (int s = 0; s < max_steps; s++) begin
            ins = imem[ipc[7:0]];
            op = ins[15:12]; rs = ins[11:9]; rt = ins[8:6]; rd = ins[5:3]; fn = ins[2:0];
            a = r[rs]; b = r[rt];
            imm = {{26{ins[5]}}, ins[5:0]};
            nxt = ipc + 16'd1;
            lat = 4;
            if (op == 4'hF) begin
                rrec.pc = ipc; rrec.lat = 3;
                ret_q.push_back(rrec);
                exp_halted = 1'b1;
                exp_pc = ipc;
                return;
            end
            if (op >= 4'h9) begin
                exp_err = 1'b1;
                exp_pc = ipc;
                return;
            end
            case (op)
                4'h0: begin
                    case (fn)
                        3'd0: res = a + b;
                        3'd1: res = a - b;
                        3'd2: res = a & b;
                        3'd3: res = a | b;
                        3'd4: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd5: res = a ^ b;
                        3'd6: res = a << b[4:0];
                        default: res = a >> b[4:0];
                    endcase
                    if (rd != 3'd0) r[rd] = res;
                end
                4'h1: if (rt != 3'd0) r[rt] = a + imm;
                4'h2: if (rt != 3'd0) r[rt] = a & imm;
                4'h3: if (rt != 3'd0) r[rt] = a | imm;
                4'h4: if (rt != 3'd0) r[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                4'h5, 4'h6: begin
                    addr = a + imm;
                    d = (fixed_delay[ipc[7:0]] >= 0) ? fixed_delay[ipc[7:0]] : $urandom_range(0, 3);
                    delay_q.push_back(d);
                    mrec.we = (op == 4'h6); mrec.addr = addr; mrec.wdata = b;
                    mem_q.push_back(mrec);
                    if (op == 4'h6) begin
                        iss_mem[addr] = b;
                        lat = 4 + d;
                    end else begin
                        res = iss_mem.exists(addr) ? iss_mem[addr] : init_word(addr);
                        if (rt != 3'd0) r[rt] = res;
                        lat = 5 + d;
                    end
                end
                default: begin
                    lat = 3;
                    if ((op == 4'h7) == (a == b)) nxt = ipc + 16'd1 + imm[15:0];
                end
            endcase
            rrec.pc = ipc; rrec.lat = lat;
            ret_q.push_back(rrec);
            ipc = nxt;
        end
        exp_pc = ipc;
    endtask

    // Instruction ROM: one-cycle synchronous read
    always @(posedge clock) imem_rdata <= imem[imem_addr[7:0]];

    // Data memory responder: acks after the queued number of wait cycles
    initial begin
        logic busy;
        int   cnt;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            dmem_ack = 1'b0;
            if (reset_n && dmem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
                end
                if (cnt == 0) begin
                    dmem_ack = 1'b1;
                    busy = 1'b0;
                    if (dmem_we) resp_mem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = resp_mem.exists(dmem_addr) ? resp_mem[dmem_addr]
                                                                 : init_word(dmem_addr);
                end else begin
                    cnt--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: compares data accesses and retirements against the scoreboard queues
    initial begin
        int   cyc, last;
        logic req_prev;
        mem_t cur;
        ret_t rr;
        cyc = 0; last = 0; req_prev = 1'b0;
        cur.we = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                cyc = 0; last = 0; req_prev = 1'b0;
            end else begin
                cyc++;
                if (dmem_req) begin
                    if (!req_prev) begin
                        if (mem_q.size() == 0) begin
                            chk("unexpected_dmem_req", {32'h0, dmem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            cur = mem_q.pop_front();
                            chk("dmem_we", dmem_we, cur.we);
                            chk("dmem_addr", dmem_addr, cur.addr);
                            if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
                            $display("mem we=%0d addr=%0h wdata=%0h", dmem_we, dmem_addr, dmem_wdata);
                        end
                    end else begin
                        chk("dmem_we_hold", dmem_we, cur.we);
                        chk("dmem_addr_hold", dmem_addr, cur.addr);
                    end
                end
                req_prev = dmem_req;
                if (retire) begin
                    if (ret_q.size() == 0) begin
                        chk("unexpected_retire", pc, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        rr = ret_q.pop_front();
                        chk("retire_pc", pc, rr.pc);
                        chk("retire_latency", cyc - last, rr.lat);
                        $display("retire pc=%0d lat=%0d", pc, cyc - last);
                    end
                    last = cyc;
                end
            end
        end
    end

    task automatic clear_env();
        ret_q.delete(); mem_q.delete(); delay_q.delete(); resp_mem.delete();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hF000;
            fixed_delay[i] = -1;
        end
    endtask

    task automatic assert_reset();
        @(posedge clock); #2;
        reset_n = 1'b0;
        mon_en = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        #2;
        chk("reset_pc", pc, 16'h0);
        chk("reset_req", dmem_req, 1'b0);
        chk("reset_flags", {retire, halted, err}, 3'b000);
        reset_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic run_check(input bit terminal);
        int n;
        n = 0;
        while (ret_q.size() != 0 || mem_q.size() != 0) begin
            @(posedge clock); #2;
            n++;
            if (n > 3000) begin
                chk("timeout_pending", ret_q.size() + mem_q.size(), 0);
                break;
            end
        end
        if (terminal) begin
            repeat (12) @(posedge clock);
            #2;
            chk("halted", halted, exp_halted);
            chk("err", err, exp_err);
            chk("final_pc", pc, exp_pc);
        end
        mon_en = 1'b0;
    endtask

    initial begin
        // Phase A: directed sequence then random instructions, ending in halt
        clear_env();
        imem[0]  = enc_i(4'h1, 3'd0, 3'd1, 6'd5);
        imem[1]  = enc_i(4'h1, 3'd0, 3'd2, 6'h3D);
        imem[2]  = enc_r(3'd1, 3'd2, 3'd3, 3'd0);
        imem[3]  = enc_i(4'h6, 3'd0, 3'd3, 6'd2);
        imem[4]  = enc_i(4'h5, 3'd0, 3'd6, 6'd2);
        imem[5]  = enc_i(4'h1, 3'd0, 3'd1, 6'd1);
        imem[6]  = enc_r(3'd0, 3'd1, 3'd4, 3'd1);
        imem[7]  = enc_i(4'h8, 3'd1, 3'd1, 6'd4);
        imem[8]  = enc_r(3'd4, 3'd0, 3'd5, 3'd4);
        imem[9]  = enc_i(4'h1, 3'd0, 3'd0, 6'd7);
        imem[10] = enc_i(4'h6, 3'd5, 3'd0, 6'd0);
        imem[11] = enc_i(4'h6, 3'd5, 3'd6, 6'd3);
        imem[12] = enc_i(4'h7, 3'd1, 3'd1, 6'd1);
        imem[13] = 16'h9000;
        for (int i = 14; i < 54; i++) imem[i] = rand_instr();
        fixed_delay[3] = 0;
        fixed_delay[4] = 3;
        iss_run(200);
        assert_reset();
        release_reset();
        run_check(1'b1);

        // Phase B: beq r1,r1,-1 at pc 7 spins on itself
        assert_reset();
        clear_env();
        for (int i = 0; i < 7; i++) imem[i] = enc_i(4'h1, 3'd0, 3'd1, 6'(i));
        imem[7] = enc_i(4'h7, 3'd1, 3'd1, 6'h3F);
        iss_run(12);
        release_reset();
        run_check(1'b0);

        // Phase C: illegal opcode traps with pc frozen and no memory traffic
        assert_reset();
        clear_env();
        imem[0] = enc_i(4'h1, 3'd0, 3'd1, 6'd1);
        imem[1] = {4'($urandom_range(9, 14)), 12'h0};
        iss_run(10);
        release_reset();
        run_check(1'b1);

        // Phase D: reset asserted while a load waits for its ack
        assert_reset();
        clear_env();
        imem[0] = enc_i(4'h6, 3'd0, 3'd1, 6'd3);
        imem[1] = enc_i(4'h1, 3'd0, 3'd1, 6'd5);
        imem[2] = enc_i(4'h5, 3'd1, 3'd2, 6'd0);
        imem[3] = enc_i(4'h6, 3'd0, 3'd2, 6'd0);
        delay_q.push_back(0);
        delay_q.push_back(1000);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        begin
            int n;
            n = 0;
            while (!(dmem_req && !dmem_we) && n < 100) begin
                @(posedge clock); #2;
                n++;
            end
            chk("load_wait_reached", dmem_req && !dmem_we, 1'b1);
        end
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset_req", dmem_req, 1'b0);
        chk("midreset_pc", pc, 16'h0);
        chk("midreset_retire", retire, 1'b0);
        @(posedge clock); #2;
        ret_q.delete(); mem_q.delete(); delay_q.delete(); resp_mem.delete();
        iss_run(20);
        release_reset();
        run_check(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
